// File: rtl/enc_pkg.sv
// enc_pkg: quadrature Gray-state encoding shared by the encoder generator and the QEI decoder.
package enc_pkg;
  localparam logic [1:0] QS0 = 2'b00;
  localparam logic [1:0] QS1 = 2'b10;
  localparam logic [1:0] QS2 = 2'b11;
  localparam logic [1:0] QS3 = 2'b01;
  function automatic logic [1:0] pos_to_ab(input logic [1:0] p);
    return p == 2'd0 ? QS0 : p == 2'd1 ? QS1 : p == 2'd2 ? QS2 : QS3;
  endfunction
endpackage

// File: rtl/step_timer.sv
// step_timer: paces quadrature counts, firing once every max(period, 2) enabled cycles.
module step_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PER_W-1:0] period,
  output logic             fire
);
  logic [PER_W-1:0] cnt, per_eff;
  assign per_eff = period < PER_W'(2) ? PER_W'(2) : period;
  // >= rather than == so a live cut of period takes effect without wrapping cnt
  assign fire = en && cnt >= per_eff - PER_W'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (!en || clr || fire) ? '0 : cnt + PER_W'(1);
endmodule

// File: rtl/quad_enc_gen.sv
// quad_enc_gen: synthesizes registered A/B/Z quadrature outputs from a step period and direction.
module quad_enc_gen
  import enc_pkg::*;
#(
  parameter int CPR = 2048,
  parameter int PER_W = 16,
  localparam int POS_W = $clog2(CPR)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             dir,
  input  logic [PER_W-1:0] period,
  input  logic             load,
  input  logic [POS_W-1:0] load_pos,
  output logic [2:0]       enc_abz,
  output logic [POS_W-1:0] pos,
  output logic             step
);
  logic fire, load_ok;
  logic [POS_W-1:0] pos_inc, pos_dec, pos_n;
  assign load_ok = load && int'(load_pos) < CPR;
  assign pos_inc = pos == POS_W'(CPR - 1) ? '0 : pos + POS_W'(1);
  assign pos_dec = pos == '0 ? POS_W'(CPR - 1) : pos - POS_W'(1);
  assign pos_n = load_ok ? load_pos : fire ? (dir ? pos_inc : pos_dec) : pos;
  step_timer #(.PER_W(PER_W)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .clr(load_ok),
    .period(period),
    .fire(fire)
  );
  // A/B/Z all come from pos_n so they update on the same edge as pos
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pos <= '0;
      enc_abz <= 3'b001;
      step <= 1'b0;
    end else begin
      pos <= pos_n;
      enc_abz <= {pos_to_ab(pos_n[1:0]), pos_n == '0};
      step <= fire && !load_ok;
    end
endmodule
